ex_mem_stage_reg: RTL and testbench
===================================

# ex_mem_stage_reg

EX/MEM pipeline register of the RISC-V core; the producer of the `ex_mem_rd` destination-register index consumed by the forwarding and hazard logic. It captures EX-stage results and control and presents them to the MEM stage and to the forwarding/hazard unit. It also performs store-data lane replication and byte-enable generation, and supports stall/flush control. One-cycle registered latency; all outputs come directly from flops.

## Interface
- No parameters; data width fixed at 32, register index fixed at 5.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `stall`  in  1  hold current contents
- `flush`  in  1  load a bubble on the next edge
- `id_ex_valid`  in  1  EX stage holds a real instruction
- `id_ex_rd`  in  5  destination register index
- `id_ex_reg_write`  in  1  instruction writes rd
- `id_ex_mem_read`  in  1  load
- `id_ex_mem_write`  in  1  store
- `id_ex_mem_to_reg`  in  1  writeback selects memory data
- `id_ex_funct3`  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- `alu_result`  in  32  ALU result / effective address
- `rs2_data`  in  32  raw store data
- `ex_mem_valid`  out  1  register holds a real instruction
- `ex_mem_rd`  out  5  destination index; 0 when no write
- `ex_mem_reg_write`  out  1  qualified write enable
- `ex_mem_mem_read`  out  1  qualified load
- `ex_mem_mem_write`  out  1  qualified store
- `ex_mem_mem_to_reg`  out  1  passthrough
- `ex_mem_funct3`  out  3  passthrough
- `ex_mem_alu_result`  out  32  address/result
- `ex_mem_store_data`  out  32  lane-replicated store data
- `ex_mem_byte_en`  out  4  byte lanes for the memory access
- `ex_mem_load_pending`  out  1  load with nonzero rd present
- `ex_mem_misaligned`  out  1  captured access was misaligned
- `stall_cnt`, `bubble_cnt`  out  32 each  performance counters (present only with `EX_MEM_PERF_CNT_EN`)

## Operation
- Next-state priority: `flush` > `stall` > capture.
- **Capture:** when neither flush nor stall is asserted, all fields load from the inputs.
- **Stall:** when stall is asserted and flush is not, all outputs hold.
- **Flush, or capture with `id_ex_valid=0`:** bubble; every output register becomes 0.
- **Write qualification:**
  - `ex_mem_reg_write = id_ex_valid & id_ex_reg_write & (id_ex_rd != 0)`.
  - `ex_mem_rd` = `id_ex_rd` when the qualified write is 1, otherwise 0.
  - The consumer never sees a false hazard on x0 or on non-writing instructions.
- **Store data:**
  - B: `{4{rs2[7:0]}}`
  - H: `{2{rs2[15:0]}}`
  - W: `rs2`
- **Byte enable:** computed for loads and stores from `alu_result[1:0]` and size.
  - B: one-hot `1<<addr[1:0]`.
  - H: `0011` or `1100` by `addr[1]`.
  - W: `1111`.
  - 0 when neither load nor store.
- **Misalignment:**
  - H with `addr[0]=1`, or W with `addr[1:0]!=0`, is misaligned.
  - On a misaligned access, `ex_mem_misaligned=1` and `mem_read`, `mem_write`, `byte_en` and `reg_write` are forced to 0.
  - `ex_mem_rd` is then 0; valid stays 1.
- `ex_mem_load_pending = ex_mem_mem_read & (ex_mem_rd != 0)`, registered together with the other fields.
- funct3 values other than those listed are treated as W for lane and enable logic.

## Timing
- Latency: inputs present at edge N appear on the outputs after edge N.
- Reset (asynchronous assert, synchronous release): every output, including the counters, is 0 immediately.
- Reset asserted mid-stall or mid-flush clears state at once; the first capture happens on the first edge after deassertion.
- Stall held K cycles: outputs are constant for K edges.
- Flush and stall in the same cycle: bubble.
- Back-to-back flushes: consecutive bubbles.
- No combinational path from any input to any output.

## Configuration
- `EX_MEM_PERF_CNT_EN` defined:
  - `stall_cnt` increments on every edge where `stall & ~flush`.
  - `bubble_cnt` increments on every edge where a bubble is loaded.
  - Both are 32-bit wrapping counters (`FFFFFFFF` → `0`), reset to 0.
- Not defined: the counter ports and their logic do not exist.

## Test plan
- Reset with all inputs nonzero → all outputs 0. Release reset, then `add` with rd=5, valid=1 → after one edge `ex_mem_rd=5`, `reg_write=1`, `valid=1`.
- rd=0 with `reg_write=1`, and separately rd=7 with `reg_write=0` → both give `ex_mem_rd=0`, `ex_mem_reg_write=0`.
- SB with addr `0x1003`, `rs2=0xAABBCCDD` → `store_data=0xDDDDDDDD`, `byte_en=1000`. SH with addr `0x1002` → `store_data=0xCCDDCCDD`, `byte_en=1100`.
- LW with addr `0x1002`, rd=9 → `misaligned=1`, `mem_read=0`, `ex_mem_rd=0`, `load_pending=0`. LW with addr `0x1000`, rd=9 → `load_pending=1`, `ex_mem_rd=9`.
- Capture rd=3, then `stall` for 3 cycles while inputs change → outputs hold rd=3. Then `stall`=`flush`=1 → bubble; with the macro enabled, `stall_cnt=3` and `bubble_cnt=1`.
- Assert `rst` mid-stall → outputs 0 asynchronously, counters 0.

Source files
------------

// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg: EX/MEM pipeline register with write qualification, store lane replication and byte enables.
// Optional performance counters (stall_cnt, bubble_cnt) are built when EX_MEM_PERF_CNT_EN is defined.
module ex_mem_stage_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_ex_valid,
  input  logic [4:0]  id_ex_rd,
  input  logic        id_ex_reg_write,
  input  logic        id_ex_mem_read,
  input  logic        id_ex_mem_write,
  input  logic        id_ex_mem_to_reg,
  input  logic [2:0]  id_ex_funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  output logic        ex_mem_valid,
  output logic [4:0]  ex_mem_rd,
  output logic        ex_mem_reg_write,
  output logic        ex_mem_mem_read,
  output logic        ex_mem_mem_write,
  output logic        ex_mem_mem_to_reg,
  output logic [2:0]  ex_mem_funct3,
  output logic [31:0] ex_mem_alu_result,
  output logic [31:0] ex_mem_store_data,
  output logic [3:0]  ex_mem_byte_en,
  output logic        ex_mem_load_pending,
  output logic        ex_mem_misaligned
`ifdef EX_MEM_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt
`endif
);
  logic is_b, is_h, acc, mis, keep, load;
  logic n_valid, n_reg_write, n_mem_read, n_mem_write, n_mem_to_reg, n_lp, n_mis;
  logic [4:0] n_rd;
  logic [2:0] n_funct3;
  logic [3:0] n_be;
  logic [31:0] n_alu, n_sd;
  // Unlisted funct3 encodings fall through to word handling.
  always_comb begin
    is_b = id_ex_funct3 == 3'b000 || id_ex_funct3 == 3'b100;
    is_h = id_ex_funct3 == 3'b001 || id_ex_funct3 == 3'b101;
    acc = id_ex_mem_read | id_ex_mem_write;
    mis = acc & (is_h ? alu_result[0] : (!is_b && alu_result[1:0] != 2'b00));
    keep = ~flush & id_ex_valid;
    n_valid = keep;
    n_mis = keep & mis;
    n_reg_write = keep & id_ex_reg_write & (id_ex_rd != 5'd0) & ~mis;
    n_rd = n_reg_write ? id_ex_rd : 5'd0;
    n_mem_read = keep & id_ex_mem_read & ~mis;
    n_mem_write = keep & id_ex_mem_write & ~mis;
    n_mem_to_reg = keep & id_ex_mem_to_reg;
    n_funct3 = keep ? id_ex_funct3 : 3'b000;
    n_alu = keep ? alu_result : 32'd0;
    n_sd = !keep ? 32'd0 : is_b ? {4{rs2_data[7:0]}} : is_h ? {2{rs2_data[15:0]}} : rs2_data;
    n_be = !(keep & acc & ~mis) ? 4'b0000 :
           is_b ? 4'b0001 << alu_result[1:0] :
           is_h ? (alu_result[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    n_lp = n_mem_read & (n_rd != 5'd0);
  end
  assign load = flush | ~stall;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ex_mem_valid <= 1'b0;
      ex_mem_rd <= 5'd0;
      ex_mem_reg_write <= 1'b0;
      ex_mem_mem_read <= 1'b0;
      ex_mem_mem_write <= 1'b0;
      ex_mem_mem_to_reg <= 1'b0;
      ex_mem_funct3 <= 3'b000;
      ex_mem_alu_result <= 32'd0;
      ex_mem_store_data <= 32'd0;
      ex_mem_byte_en <= 4'b0000;
      ex_mem_load_pending <= 1'b0;
      ex_mem_misaligned <= 1'b0;
    end else if (load) begin
      ex_mem_valid <= n_valid;
      ex_mem_rd <= n_rd;
      ex_mem_reg_write <= n_reg_write;
      ex_mem_mem_read <= n_mem_read;
      ex_mem_mem_write <= n_mem_write;
      ex_mem_mem_to_reg <= n_mem_to_reg;
      ex_mem_funct3 <= n_funct3;
      ex_mem_alu_result <= n_alu;
      ex_mem_store_data <= n_sd;
      ex_mem_byte_en <= n_be;
      ex_mem_load_pending <= n_lp;
      ex_mem_misaligned <= n_mis;
    end
`ifdef EX_MEM_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_cnt <= 32'd0;
      bubble_cnt <= 32'd0;
    end else begin
      if (stall && !flush) stall_cnt <= stall_cnt + 32'd1;
      if (load && !keep) bubble_cnt <= bubble_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// tb_ex_mem_stage_reg: directed-vector bench for ex_mem_stage_reg with hand-computed expectations.
module tb_ex_mem_stage_reg;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, flush = 1'b0;
  logic id_ex_valid, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg;
  logic [4:0] id_ex_rd;
  logic [2:0] id_ex_funct3;
  logic [31:0] alu_result, rs2_data;
  logic ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write, ex_mem_mem_to_reg;
  logic ex_mem_load_pending, ex_mem_misaligned;
  logic [4:0] ex_mem_rd;
  logic [2:0] ex_mem_funct3;
  logic [31:0] ex_mem_alu_result, ex_mem_store_data;
  logic [3:0] ex_mem_byte_en;
`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif
  int checks = 0, errors = 0;

  ex_mem_stage_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_ex_valid(id_ex_valid), .id_ex_rd(id_ex_rd), .id_ex_reg_write(id_ex_reg_write),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_mem_write(id_ex_mem_write),
    .id_ex_mem_to_reg(id_ex_mem_to_reg), .id_ex_funct3(id_ex_funct3),
    .alu_result(alu_result), .rs2_data(rs2_data),
    .ex_mem_valid(ex_mem_valid), .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
    .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_mem_write(ex_mem_mem_write),
    .ex_mem_mem_to_reg(ex_mem_mem_to_reg), .ex_mem_funct3(ex_mem_funct3),
    .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_store_data(ex_mem_store_data),
    .ex_mem_byte_en(ex_mem_byte_en), .ex_mem_load_pending(ex_mem_load_pending),
    .ex_mem_misaligned(ex_mem_misaligned)
`ifdef EX_MEM_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                       input logic mw, input logic m2r, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] rs2);
    id_ex_valid = v; id_ex_rd = rd; id_ex_reg_write = rw; id_ex_mem_read = mr;
    id_ex_mem_write = mw; id_ex_mem_to_reg = m2r; id_ex_funct3 = f3;
    alu_result = alu; rs2_data = rs2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(ex_mem_valid), 32'd0);
    chk({tag, "_rd"}, 32'(ex_mem_rd), 32'd0);
    chk({tag, "_rw"}, 32'(ex_mem_reg_write), 32'd0);
    chk({tag, "_mr_mw_m2r"}, 32'({ex_mem_mem_read, ex_mem_mem_write, ex_mem_mem_to_reg}), 32'd0);
    chk({tag, "_f3"}, 32'(ex_mem_funct3), 32'd0);
    chk({tag, "_alu"}, ex_mem_alu_result, 32'd0);
    chk({tag, "_sd"}, ex_mem_store_data, 32'd0);
    chk({tag, "_be"}, 32'(ex_mem_byte_en), 32'd0);
    chk({tag, "_lp_mis"}, 32'({ex_mem_load_pending, ex_mem_misaligned}), 32'd0);
  endtask

  initial begin
    drive(1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    stall = 1'b1; flush = 1'b1;
    repeat (3) tick();
    chk_zero("reset");
`ifdef EX_MEM_PERF_CNT_EN
    chk("reset_scnt", stall_cnt, 32'd0);
    chk("reset_bcnt", bubble_cnt, 32'd0);
`endif
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0);
    tick();
    chk("add_rd", 32'(ex_mem_rd), 32'd5);
    chk("add_rw", 32'(ex_mem_reg_write), 32'd1);
    chk("add_valid", 32'(ex_mem_valid), 32'd1);
    chk("add_alu", ex_mem_alu_result, 32'h0000_1234);
    chk("add_be", 32'(ex_mem_byte_en), 32'd0);
    drive(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h10, 32'h0);
    tick();
    chk("x0_rd", 32'(ex_mem_rd), 32'd0);
    chk("x0_rw", 32'(ex_mem_reg_write), 32'd0);
    chk("x0_valid", 32'(ex_mem_valid), 32'd1);
    drive(1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h10, 32'h0);
    tick();
    chk("nowr_rd", 32'(ex_mem_rd), 32'd0);
    chk("nowr_rw", 32'(ex_mem_reg_write), 32'd0);
    drive(1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'hAABB_CCDD);
    tick();
    chk("sb_sd", ex_mem_store_data, 32'hDDDD_DDDD);
    chk("sb_be", 32'(ex_mem_byte_en), 32'b1000);
    chk("sb_mw", 32'(ex_mem_mem_write), 32'd1);
    chk("sb_mis", 32'(ex_mem_misaligned), 32'd0);
    drive(1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 32'h0000_1002, 32'hAABB_CCDD);
    tick();
    chk("sh_sd", ex_mem_store_data, 32'hCCDD_CCDD);
    chk("sh_be", 32'(ex_mem_byte_en), 32'b1100);
    chk("sh_f3", 32'(ex_mem_funct3), 32'd1);
    drive(1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 32'h0000_1001, 32'hAABB_CCDD);
    tick();
    chk("shmis_mis", 32'(ex_mem_misaligned), 32'd1);
    chk("shmis_mw", 32'(ex_mem_mem_write), 32'd0);
    chk("shmis_be", 32'(ex_mem_byte_en), 32'd0);
    drive(1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_1002, 32'h0);
    tick();
    chk("lwmis_mis", 32'(ex_mem_misaligned), 32'd1);
    chk("lwmis_mr", 32'(ex_mem_mem_read), 32'd0);
    chk("lwmis_rd", 32'(ex_mem_rd), 32'd0);
    chk("lwmis_rw", 32'(ex_mem_reg_write), 32'd0);
    chk("lwmis_lp", 32'(ex_mem_load_pending), 32'd0);
    chk("lwmis_valid", 32'(ex_mem_valid), 32'd1);
    drive(1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_1000, 32'h0);
    tick();
    chk("lw_lp", 32'(ex_mem_load_pending), 32'd1);
    chk("lw_rd", 32'(ex_mem_rd), 32'd9);
    chk("lw_mr", 32'(ex_mem_mem_read), 32'd1);
    chk("lw_be", 32'(ex_mem_byte_en), 32'b1111);
    chk("lw_m2r", 32'(ex_mem_mem_to_reg), 32'd1);
    drive(1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 32'h0000_2001, 32'h0);
    tick();
    chk("lbu_be", 32'(ex_mem_byte_en), 32'b0010);
    chk("lbu_lp", 32'(ex_mem_load_pending), 32'd1);
    drive(1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 32'h0000_0003, 32'h1234_5678);
    tick();
    chk("alu_nomis", 32'(ex_mem_misaligned), 32'd0);
    chk("alu_rd", 32'(ex_mem_rd), 32'd2);
    drive(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_0333, 32'h0);
    tick();
    drive(1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 32'h0000_0C00, 32'h0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_rd", i), 32'(ex_mem_rd), 32'd3);
      chk($sformatf("stall%0d_alu", i), ex_mem_alu_result, 32'h0000_0333);
    end
    flush = 1'b1;
    tick();
    chk_zero("stflush");
`ifdef EX_MEM_PERF_CNT_EN
    chk("stflush_scnt", stall_cnt, 32'd3);
    chk("stflush_bcnt", bubble_cnt, 32'd1);
`endif
    stall = 1'b0; flush = 1'b0;
    drive(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h66, 32'h0);
    tick();
    chk("pre_flush_rd", 32'(ex_mem_rd), 32'd6);
    flush = 1'b1;
    tick();
    chk("flush1_valid", 32'(ex_mem_valid), 32'd0);
    tick();
    chk("flush2_valid", 32'(ex_mem_valid), 32'd0);
    chk("flush2_rd", 32'(ex_mem_rd), 32'd0);
    flush = 1'b0;
    drive(1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 32'h66, 32'h0);
    tick();
    chk_zero("invalid");
`ifdef EX_MEM_PERF_CNT_EN
    chk("invalid_bcnt", bubble_cnt, 32'd4);
`endif
    drive(1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h88, 32'h0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    stall = 1'b1;
    tick();
    chk("stall_inv_rd", 32'(ex_mem_rd), 32'd8);
    chk("stall_inv_valid", 32'(ex_mem_valid), 32'd1);
    drive(1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'hDD, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk_zero("async_rst");
`ifdef EX_MEM_PERF_CNT_EN
    chk("async_rst_scnt", stall_cnt, 32'd0);
    chk("async_rst_bcnt", bubble_cnt, 32'd0);
`endif
    tick();
    chk("rst_held_rd", 32'(ex_mem_rd), 32'd0);
    rst = 1'b0; stall = 1'b0;
    drive(1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'hBB, 32'h0);
    tick();
    chk("post_rst_rd", 32'(ex_mem_rd), 32'd11);
    chk("post_rst_valid", 32'(ex_mem_valid), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
